uart_tx: RTL and testbench

- Serial transmitter that drains a sync_fifo read port: consumes bytes over a valid/ready handshake and shifts them out as 8N1 (optionally 8E1) async serial frames.
- Sits directly downstream of the TX byte FIFO. Its in_* ports connect straight to the FIFO's rd_data, rd_valid and rd_ready.
- Sustains back-to-back frames with zero idle bits whenever the FIFO stays non-empty.

---
 rtl/uart_tx.sv | 180 ++++++++++++++++++
 tb/tb_uart_tx.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: byte-stream to asynchronous serial (8N1, or 8E1 with parity).
// Drains a FIFO read port over valid/ready and emits frames back to back
// while bytes keep arriving. Build option: define UART_TX_PARITY_EN to
// insert an even parity bit between data bit 7 and the first stop bit.
// All outputs are registered; every output register is loaded from the
// next-state values so that it lines up with the state it describes.

module uart_tx #(
    parameter int DIVISOR  = 434,
    parameter int STOPBITS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       txd,
    output logic       busy
);

    localparam int             CW        = $clog2(DIVISOR);
    localparam logic [CW-1:0]  LAST_TICK = CW'(DIVISOR - 1);
    localparam logic           LAST_STOP = 1'(STOPBITS - 1);

    generate
        if (DIVISOR < 2) begin : g_bad_divisor
            $error("uart_tx: DIVISOR must be at least 2");
        end
        if (STOPBITS != 1 && STOPBITS != 2) begin : g_bad_stopbits
            $error("uart_tx: STOPBITS must be 1 or 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_n;
    logic [2:0]      bit_idx;
    logic [2:0]      bit_n;
    logic            stop_idx;
    logic            stop_n;
    logic [7:0]      data_q;
    logic [7:0]      data_n;
    logic            txd_n;
    logic            in_ready_n;
    logic            busy_n;
    logic            accept;
    logic            last_tick;

    assign accept    = in_valid & in_ready;
    assign last_tick = (cnt == LAST_TICK);

    // State, counters, latched byte and the registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            data_q   <= '0;
            txd      <= 1'b1;
            in_ready <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            bit_idx  <= bit_n;
            stop_idx <= stop_n;
            data_q   <= data_n;
            txd      <= txd_n;
            in_ready <= in_ready_n;
            busy     <= busy_n;
        end
    end

    // Next-state logic: the divider reloads on every bit boundary.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bit_n   = bit_idx;
        stop_n  = stop_idx;
        data_n  = data_q;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (accept) begin
                    state_n = START;
                    data_n  = in_data;
                end
            end
            START: begin
                if (last_tick) begin
                    state_n = DATA;
                    cnt_n   = '0;
                    bit_n   = 3'd0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            DATA: begin
                if (last_tick) begin
                    cnt_n = '0;
                    if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                        stop_n = 1'b0;
                    end else begin
                        bit_n = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (last_tick) begin
                    state_n = STOP;
                    cnt_n   = '0;
                    stop_n  = 1'b0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
`endif
            STOP: begin
                if (last_tick) begin
                    cnt_n = '0;
                    if (stop_idx == LAST_STOP) begin
                        // A byte taken in the final stop cycle starts the
                        // next frame immediately, leaving no idle gap.
                        if (accept) begin
                            state_n = START;
                            data_n  = in_data;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        stop_n = stop_idx + 1'b1;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Output decode from the next state so the registers match it.
    always_comb begin
        txd_n      = 1'b1;
        busy_n     = (state_n != IDLE);
        in_ready_n = (state_n == IDLE) ||
                     ((state_n == STOP) && (cnt_n == LAST_TICK) && (stop_n == LAST_STOP));
        case (state_n)
            START:   txd_n = 1'b0;
            DATA:    txd_n = data_n[bit_n];
`ifdef UART_TX_PARITY_EN
            PARITY:  txd_n = ^data_n;
`endif
            default: txd_n = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx.
// Three instances share clock, reset and data: a (DIVISOR=4, 1 stop bit),
// b (DIVISOR=4, 2 stop bits) and c (DIVISOR=2, 1 stop bit). Expected
// line patterns are written out by hand in transmission order.
// Honours UART_TX_PARITY_EN the same way as the design.

module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic       clk;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    int         sel;

    logic valid_a, valid_b, valid_c;
    logic ready_a, ready_b, ready_c;
    logic txd_a, txd_b, txd_c;
    logic busy_a, busy_b, busy_c;
    logic cur_txd, cur_ready, cur_busy;

    int total;
    int bad;
    int acc_a;

    typedef struct {
        int         sel;
        logic [7:0] data;
        string      line;
        logic       par;
    } vec_t;

    vec_t vecs[7];

    assign valid_a = in_valid && (sel == 0);
    assign valid_b = in_valid && (sel == 1);
    assign valid_c = in_valid && (sel == 2);

    uart_tx #(.DIVISOR(4), .STOPBITS(1)) dut_a (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(valid_a),
        .in_ready(ready_a), .txd(txd_a), .busy(busy_a)
    );

    uart_tx #(.DIVISOR(4), .STOPBITS(2)) dut_b (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(valid_b),
        .in_ready(ready_b), .txd(txd_b), .busy(busy_b)
    );

    uart_tx #(.DIVISOR(2), .STOPBITS(1)) dut_c (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(valid_c),
        .in_ready(ready_c), .txd(txd_c), .busy(busy_c)
    );

    // Route the selected instance's outputs to the shared checks.
    always_comb begin
        cur_txd   = txd_a;
        cur_ready = ready_a;
        cur_busy  = busy_a;
        if (sel == 1) begin
            cur_txd   = txd_b;
            cur_ready = ready_b;
            cur_busy  = busy_b;
        end else if (sel == 2) begin
            cur_txd   = txd_c;
            cur_ready = ready_c;
            cur_busy  = busy_c;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count handshakes seen by instance a.
    always @(posedge clk) begin
        if (valid_a && ready_a) acc_a++;
    end

    task automatic check_output(input string name, input logic actual, input logic expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s at %0t: got %b want %b", name, $time, actual, expected);
        end
    endtask

    task automatic check_count(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d want %0d", name, actual, expected);
        end
    endtask

    function automatic int div_of(input int s);
        return (s == 2) ? 2 : 4;
    endfunction

    function automatic int frame_bits(input int s);
        return 9 + ((s == 1) ? 2 : 1) + PB;
    endfunction

    // Step to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) until the selected instance offers in_ready.
    task automatic wait_ready();
        int n;
        n = 0;
        while (!cur_ready && n < 200) begin
            tick();
            n++;
        end
        if (!cur_ready) check_output("wait_ready_timeout", cur_ready, 1'b1);
    endtask

    // Present a byte; the next rising edge is the accept edge.
    task automatic apply_stimulus(input int s, input logic [7:0] d);
        sel      = s;
        in_data  = d;
        in_valid = 1'b1;
        wait_ready();
    endtask

    // Follow one frame cycle by cycle from its accept edge. With chain set,
    // in_valid stays high and the next byte is offered in the final stop cycle.
    task automatic run_frame(input string line, input logic par,
                             input bit chain, input logic [7:0] next_data);
        int   d;
        int   f;
        int   p;
        logic exp_txd;
        d = div_of(sel);
        f = frame_bits(sel);
        for (int k = 0; k < f * d; k++) begin
            tick();
            if (k == 0 && !chain) in_valid = 1'b0;
            p = k / d;
            if (p == 0)                   exp_txd = 1'b0;
            else if (p <= 8)              exp_txd = (line.getc(p - 1) == "1");
            else if (PB == 1 && p == 9)   exp_txd = par;
            else                          exp_txd = 1'b1;
            check_output("txd", cur_txd, exp_txd);
            check_output("busy", cur_busy, 1'b1);
            check_output("in_ready", cur_ready, (k == f * d - 1));
            if (k == f * d - 1 && chain) in_data = next_data;
        end
        if (!chain) begin
            tick();
            check_output("idle_busy", cur_busy, 1'b0);
            check_output("idle_ready", cur_ready, 1'b1);
            check_output("idle_txd", cur_txd, 1'b1);
        end
    endtask

    initial begin
        int a0;
        total    = 0;
        bad      = 0;
        acc_a    = 0;
        sel      = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;

        vecs[0] = '{0, 8'hA5, "10100101", 1'b0};
        vecs[1] = '{0, 8'h01, "10000000", 1'b1};
        vecs[2] = '{0, 8'h03, "11000000", 1'b0};
        vecs[3] = '{0, 8'h4F, "11110010", 1'b1};
        vecs[4] = '{1, 8'h3C, "00111100", 1'b0};
        vecs[5] = '{2, 8'h80, "00000001", 1'b1};
        vecs[6] = '{2, 8'h4F, "11110010", 1'b1};

        // Reset held for three cycles, then released.
        for (int i = 0; i < 3; i++) begin
            tick();
            check_output("rst_txd", cur_txd, 1'b1);
            check_output("rst_busy", cur_busy, 1'b0);
            check_output("rst_ready", cur_ready, 1'b0);
        end
        rst = 1'b0;
        tick();
        check_output("rel_ready", cur_ready, 1'b1);
        check_output("rel_busy", cur_busy, 1'b0);
        check_output("rel_txd", cur_txd, 1'b1);

        // Table of single frames.
        for (int i = 0; i < 7; i++) begin
            apply_stimulus(vecs[i].sel, vecs[i].data);
            run_frame(vecs[i].line, vecs[i].par, 1'b0, 8'h00);
        end

        // Back-to-back 0x00 then 0xFF on instance a.
        apply_stimulus(0, 8'h00);
        a0 = acc_a;
        run_frame("00000000", 1'b0, 1'b1, 8'hFF);
        run_frame("11111111", 1'b0, 1'b0, 8'h00);
        check_count("accepts_a", acc_a - a0, 2);

        // Back-to-back with two stop bits: no gap after the second stop bit.
        apply_stimulus(1, 8'h3C);
        run_frame("00111100", 1'b0, 1'b1, 8'h80);
        run_frame("00000001", 1'b1, 1'b0, 8'h00);

        // DIVISOR=2 back-to-back: in_ready pulses a single cycle per frame.
        apply_stimulus(2, 8'h4F);
        run_frame("11110010", 1'b1, 1'b1, 8'hA5);
        run_frame("10100101", 1'b0, 1'b0, 8'h00);

        // Reset in the middle of the data bits of an all-zero byte.
        apply_stimulus(0, 8'h00);
        for (int k = 0; k < 15; k++) begin
            tick();
            if (k == 0) in_valid = 1'b0;
        end
        check_output("pre_rst_txd", cur_txd, 1'b0);
        rst = 1'b1;
        tick();
        check_output("mid_rst_txd", cur_txd, 1'b1);
        check_output("mid_rst_busy", cur_busy, 1'b0);
        check_output("mid_rst_ready", cur_ready, 1'b0);
        rst = 1'b0;
        tick();
        check_output("mid_rel_ready", cur_ready, 1'b1);
        apply_stimulus(0, 8'hA5);
        run_frame("10100101", 1'b0, 1'b0, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: got running want finished");
        $fatal(1, "[TB] time limit reached");
    end

endmodule
